// File: rtl/ic_trace_fifo.sv
// Timestamped debug-event capture into a first-word-fall-through FIFO; capture-to-visible latency 1 cycle.
// Never backpressures the producer: events arriving while full (and not popping) are dropped and counted.
module ic_trace_fifo #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 16,
    parameter int TS_W   = 32,
    parameter int DEPTH  = 16,
    parameter int LOST_W = 8,
    parameter int DROP_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     ev_valid,
    input  logic [TAG_W-1:0]         ev_tag,
    input  logic [1:0]               ev_fmt,
    input  logic [DATA_W-1:0]        ev_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TS_W-1:0]          out_ts,
    output logic [TAG_W-1:0]         out_tag,
    output logic [1:0]               out_fmt,
    output logic [DATA_W-1:0]        out_data,
    output logic [LOST_W-1:0]        out_lost,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [DROP_W-1:0]        drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [TS_W-1:0]   ts;
        logic [TAG_W-1:0]  tag;
        logic [1:0]        fmt;
        logic [DATA_W-1:0] data;
        logic [LOST_W-1:0] lost;
    } entry_t;

    entry_t            mem [DEPTH];
    entry_t            head;
    logic [TS_W-1:0]   ts;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     level_q;
    logic [LW-1:0]     level_nxt;
    logic              full_q;
    logic              empty_q;
    logic [LOST_W-1:0] pend_lost;
    logic [DROP_W-1:0] drop_q;
    logic              pop;
    logic              push;
    logic              drop;

    // Push is allowed into a full FIFO when the head leaves in the same cycle.
    always_comb begin
        pop       = ~empty_q & out_ready;
        push      = ev_valid & (~full_q | pop);
        drop      = ev_valid & full_q & ~pop;
        level_nxt = level_q;
        if (push && !pop) begin
            level_nxt = level_q + 1'b1;
        end else if (pop && !push) begin
            level_nxt = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts        <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            pend_lost <= '0;
            drop_q    <= '0;
        end else begin
            ts <= ts + 1'b1;
            if (clear) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                level_q   <= '0;
                full_q    <= 1'b0;
                empty_q   <= 1'b1;
                pend_lost <= '0;
                drop_q    <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                level_q <= level_nxt;
                full_q  <= (level_nxt == LW'(DEPTH));
                empty_q <= (level_nxt == '0);
                if (push) begin
                    pend_lost <= '0;
                end else if (drop && pend_lost != '1) begin
                    pend_lost <= pend_lost + 1'b1;
                end
                if (drop && drop_q != '1) begin
                    drop_q <= drop_q + 1'b1;
                end
            end
        end
    end

    // Storage has no reset; the head mux below hides stale contents while empty.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= {ts, ev_tag, ev_fmt, ev_data, pend_lost};
        end
    end

    always_comb begin
        head = '0;
        if (!empty_q) begin
            head = mem[rd_ptr];
        end
    end

    assign out_valid = ~empty_q;
    assign out_ts    = head.ts;
    assign out_tag   = head.tag;
    assign out_fmt   = head.fmt;
    assign out_data  = head.data;
    assign out_lost  = head.lost;
    assign full      = full_q;
    assign empty     = empty_q;
    assign level     = level_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_ic_trace_fifo.sv
// Scoreboard bench for ic_trace_fifo (TS_W=8 so timestamp wrap is reachable).
module tb_ic_trace_fifo;

    localparam int DEPTH = 16;

    typedef struct packed {
        logic [7:0]  ts;
        logic [15:0] tag;
        logic [1:0]  fmt;
        logic [31:0] data;
        logic [7:0]  lost;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        ev_valid = 1'b0;
    logic [15:0] ev_tag = '0;
    logic [1:0]  ev_fmt = '0;
    logic [31:0] ev_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_ts;
    logic [15:0] out_tag;
    logic [1:0]  out_fmt;
    logic [31:0] out_data;
    logic [7:0]  out_lost;
    logic        full;
    logic        empty;
    logic [4:0]  level;
    logic [15:0] drop_cnt;
    ent_t        head;

    ent_t sb[$];
    int   m_ts;
    int   m_pend;
    int   m_drop;
    int   n_chk;
    int   n_fail;

    ic_trace_fifo #(
        .DATA_W(32), .TAG_W(16), .TS_W(8), .DEPTH(DEPTH), .LOST_W(8), .DROP_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .ev_valid(ev_valid), .ev_tag(ev_tag), .ev_fmt(ev_fmt), .ev_data(ev_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ts(out_ts), .out_tag(out_tag), .out_fmt(out_fmt), .out_data(out_data),
        .out_lost(out_lost), .full(full), .empty(empty), .level(level), .drop_cnt(drop_cnt)
    );

    assign head = {out_ts, out_tag, out_fmt, out_data, out_lost};

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock: drive inputs after negedge, advance the reference model at posedge, return at next negedge.
    task automatic cycle(input bit ev, input bit rdy, input bit clr,
                         input logic [15:0] tag, input logic [1:0] fmt, input logic [31:0] data);
        ent_t e;
        bit   pop;
        bit   was_full;
        ev_valid  = ev;
        out_ready = rdy;
        clear     = clr;
        ev_tag    = tag;
        ev_fmt    = fmt;
        ev_data   = data;
        @(posedge clk);
        pop      = (sb.size() > 0) && rdy;
        was_full = (sb.size() == DEPTH);
        if (clr) begin
            sb.delete();
            m_pend = 0;
            m_drop = 0;
        end else begin
            if (pop) void'(sb.pop_front());
            if (ev && (!was_full || pop)) begin
                e.ts   = m_ts[7:0];
                e.tag  = tag;
                e.fmt  = fmt;
                e.data = data;
                e.lost = m_pend[7:0];
                sb.push_back(e);
                m_pend = 0;
            end else if (ev) begin
                if (m_pend < 255) m_pend++;
                if (m_drop < 65535) m_drop++;
            end
        end
        m_ts = (m_ts + 1) % 256;
        @(negedge clk);
        ev_valid  = 1'b0;
        out_ready = 1'b0;
        clear     = 1'b0;
    endtask

    task automatic model_reset();
        sb.delete();
        m_ts   = 0;
        m_pend = 0;
        m_drop = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({out_valid, empty, full, level, drop_cnt} !== {1'b0, 1'b1, 1'b0, 5'd0, 16'd0}) begin
            n_fail++;
            $display("FAIL reset_status: got v/e/f/lvl/drop=%b/%b/%b/%0d/%0d, need 0/1/0/0/0",
                     out_valid, empty, full, level, drop_cnt);
        end
        n_chk++;
        if (head !== '0) begin
            n_fail++;
            $display("FAIL reset_head: got %h, need 0", head);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        ent_t want;
        want = {8'd5, 16'd42, 2'd1, 32'd7, 8'd0};
        repeat (5) cycle(0, 0, 0, '0, '0, '0);
        cycle(1, 0, 0, 16'd42, 2'd1, 32'd7);
        n_chk++;
        if (out_valid !== 1'b1 || head !== want) begin
            n_fail++;
            $display("FAIL single_head: got v=%b %h, need v=1 %h", out_valid, head, want);
        end
        n_chk++;
        if (sb.size() != 1 || head !== sb[0]) begin
            n_fail++;
            $display("FAIL single_sb: got %h, scoreboard size %0d", head, sb.size());
        end
        cycle(0, 1, 0, '0, '0, '0);
        n_chk++;
        if (empty !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pop: got empty=%b valid=%b, need 1/0", empty, out_valid);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 20; i++) begin
            cycle(1, 0, 0, 16'(100 + i), 2'(i % 4), 32'(i * 3));
            if (i == 15) begin
                n_chk++;
                if (full !== 1'b1 || level !== 5'd16) begin
                    n_fail++;
                    $display("FAIL ovf_full: got full=%b level=%0d, need 1/16", full, level);
                end
            end
        end
        n_chk++;
        if (drop_cnt !== 16'd4 || level !== 5'd16) begin
            n_fail++;
            $display("FAIL ovf_drops: got drop=%0d level=%0d, need 4/16", drop_cnt, level);
        end
        n_chk++;
        if (head !== sb[0]) begin
            n_fail++;
            $display("FAIL ovf_first: got %h, need %h", head, sb[0]);
        end
        cycle(1, 1, 0, 16'd200, 2'd0, 32'hABCD);
        n_chk++;
        if (drop_cnt !== 16'd4 || level !== 5'd16) begin
            n_fail++;
            $display("FAIL ovf_pushpop: got drop=%0d level=%0d, need 4/16", drop_cnt, level);
        end
        for (int i = 0; i < DEPTH; i++) begin
            n_chk++;
            if (out_valid !== 1'b1 || head !== sb[0]) begin
                n_fail++;
                $display("FAIL ovf_drain: got v=%b %h, need %h", out_valid, head, sb[0]);
            end
            if (sb.size() == 1) begin
                n_chk++;
                if (out_tag !== 16'd200 || out_lost !== 8'd4) begin
                    n_fail++;
                    $display("FAIL ovf_lost: got tag=%0d lost=%0d, need 200/4", out_tag, out_lost);
                end
            end
            cycle(0, 1, 0, '0, '0, '0);
        end
        n_chk++;
        if (empty !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_empty: got empty=%b, need 1", empty);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] prev_ts;
        prev_ts = '0;
        cycle(0, 0, 1, '0, '0, '0);
        n_chk++;
        if (drop_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL b2b_clear: got drop=%0d, need 0", drop_cnt);
        end
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0, 16'(i), 2'd0, $urandom);
        for (int i = 0; i < 50; i++) begin
            n_chk++;
            if (head !== sb[0]) begin
                n_fail++;
                $display("FAIL b2b_head: got %h, need %h", head, sb[0]);
            end
            if (i > 0) begin
                n_chk++;
                if (out_ts !== 8'(prev_ts + 8'd1)) begin
                    n_fail++;
                    $display("FAIL b2b_ts: got %0d, need %0d", out_ts, 8'(prev_ts + 8'd1));
                end
            end
            prev_ts = out_ts;
            cycle(1, 1, 0, 16'(1000 + i), 2'(i), $urandom);
            n_chk++;
            if (level !== 5'd16 || drop_cnt !== 16'd0) begin
                n_fail++;
                $display("FAIL b2b_level: got level=%0d drop=%0d, need 16/0", level, drop_cnt);
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            n_chk++;
            if (head !== sb[0]) begin
                n_fail++;
                $display("FAIL b2b_drain: got %h, need %h", head, sb[0]);
            end
            cycle(0, 1, 0, '0, '0, '0);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0, 16'(i), 2'd2, 32'(i));
        for (int i = 0; i < 300; i++) cycle(1, 0, 0, 16'hDEAD, 2'd3, 32'(i));
        n_chk++;
        if (drop_cnt !== 16'd300) begin
            n_fail++;
            $display("FAIL sat_drop: got %0d, need 300", drop_cnt);
        end
        cycle(1, 1, 0, 16'd777, 2'd1, 32'h55);
        while (sb.size() > 1) begin
            n_chk++;
            if (head !== sb[0]) begin
                n_fail++;
                $display("FAIL sat_drain: got %h, need %h", head, sb[0]);
            end
            cycle(0, 1, 0, '0, '0, '0);
        end
        n_chk++;
        if (out_tag !== 16'd777 || out_lost !== 8'd255 || drop_cnt !== 16'd300) begin
            n_fail++;
            $display("FAIL sat_lost: got tag=%0d lost=%0d drop=%0d, need 777/255/300",
                     out_tag, out_lost, drop_cnt);
        end
        cycle(1, 0, 1, 16'd888, 2'd0, 32'h1);
        n_chk++;
        if (level !== 5'd0 || drop_cnt !== 16'd0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_clear: got level=%0d drop=%0d empty=%b, need 0/0/1", level, drop_cnt, empty);
        end
        cycle(0, 0, 0, '0, '0, '0);
        n_chk++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_clear_ev: got valid=%b, need 0", out_valid);
        end
    endtask

    task automatic test_ts_wrap();
        for (int i = 0; i < 256 && m_ts != 255; i++) cycle(0, 0, 0, '0, '0, '0);
        cycle(1, 0, 0, 16'd1, 2'd0, 32'h11);
        cycle(1, 0, 0, 16'd2, 2'd0, 32'h22);
        n_chk++;
        if (out_ts !== 8'd255 || head !== sb[0]) begin
            n_fail++;
            $display("FAIL wrap_first: got ts=%0d %h, need ts=255", out_ts, head);
        end
        cycle(0, 1, 0, '0, '0, '0);
        n_chk++;
        if (out_ts !== 8'd0 || head !== sb[0]) begin
            n_fail++;
            $display("FAIL wrap_second: got ts=%0d %h, need ts=0", out_ts, head);
        end
        cycle(0, 1, 0, '0, '0, '0);
    endtask

    task automatic test_reset_mid_burst();
        ent_t want;
        for (int i = 0; i < DEPTH + 3; i++) cycle(1, 0, 0, 16'(i), 2'd1, 32'(i));
        for (int i = 0; i < 11; i++) begin
            n_chk++;
            if (head !== sb[0]) begin
                n_fail++;
                $display("FAIL rst_pre_drain: got %h, need %h", head, sb[0]);
            end
            cycle(0, 1, 0, '0, '0, '0);
        end
        n_chk++;
        if (level !== 5'd5) begin
            n_fail++;
            $display("FAIL rst_pre_level: got %0d, need 5", level);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({out_valid, empty, full, level, drop_cnt, head} !== {1'b0, 1'b1, 1'b0, 5'd0, 16'd0, 66'd0}) begin
            n_fail++;
            $display("FAIL rst_async: got v=%b e=%b f=%b lvl=%0d drop=%0d head=%h, need reset values",
                     out_valid, empty, full, level, drop_cnt, head);
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 0, 0, 16'd9, 2'd2, 32'h99);
        want = {8'd0, 16'd9, 2'd2, 32'h99, 8'd0};
        n_chk++;
        if (out_lost !== 8'd0 || head !== want) begin
            n_fail++;
            $display("FAIL rst_first_event: got %h, need %h", head, want);
        end
        cycle(0, 1, 0, '0, '0, '0);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        model_reset();
        test_reset();
        test_single();
        test_overflow();
        test_back_to_back();
        test_saturation();
        test_ts_wrap();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ic_trace_fifo.md
# ic_trace_fifo

Hardware capture stage that sits directly upstream of the IceCream print macros. It timestamps tagged debug events (tag = source line id, value, print format) on the cycle they occur and buffers them in a first-word-fall-through FIFO. A testbench monitor or a DPI/UART drainer pops entries later and passes them to the matching `IC_HEX`/`IC_DEC`/`IC_CHAR`/`IC_STR` print. Overflow never stalls the design under debug: excess events are dropped and counted, and the count is reported in-band.

## Interface
- DATA_W, 32, width of captured value
- TAG_W, 16, width of event tag (source line number)
- TS_W, 32, width of free-running timestamp
- DEPTH, 16, FIFO entries; power of two, >= 2
- LOST_W, 8, width of per-entry lost-event count (saturating)
- DROP_W, 16, width of total drop counter (saturating)

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous flush
- ev_valid  in  1  event capture strobe
- ev_tag  in  TAG_W  event tag
- ev_fmt  in  2  print format: 0 HEX, 1 DEC, 2 CHAR, 3 STR
- ev_data  in  DATA_W  captured value
- out_valid  out  1  head entry available
- out_ready  in  1  consumer accepts head
- out_ts  out  TS_W  timestamp of head entry
- out_tag  out  TAG_W  tag of head entry
- out_fmt  out  2  format of head entry
- out_data  out  DATA_W  value of head entry
- out_lost  out  LOST_W  events dropped immediately before head entry
- full  out  1  DEPTH entries stored
- empty  out  1  zero entries stored
- level  out  $clog2(DEPTH)+1  entries stored
- drop_cnt  out  DROP_W  total dropped events since reset/clear

## Operation
- Timestamp: `ts` counter resets to 0, increments every cycle, wraps 2^TS_W-1 -> 0. `clear` does not affect it. The entry stores the `ts` value of the capture cycle.
- Push: `ev_valid && (!full || pop)` writes {ts, tag, fmt, data, pend_lost} at the write pointer. `pend_lost` then resets to 0.
- Pop: `pop = out_valid && out_ready` advances the read pointer. The head fields are valid only while `out_valid` is high.
- Drop: `ev_valid && full && !pop` discards the event. `pend_lost` increments, saturating at 2^LOST_W-1. `drop_cnt` increments, saturating at 2^DROP_W-1.
- Simultaneous push and pop when full: both occur, `level` is unchanged, and no drop occurs.
- Push when empty: no bypass. The entry becomes visible on the next cycle.
- Pointers are log2(DEPTH) bits and wrap naturally. `level` tracks occupancy; `full = (level==DEPTH)` and `empty = (level==0)`.
- `clear` has priority over push, pop and drop in the same cycle. It empties the FIFO and zeroes `pend_lost` and `drop_cnt`. An event in the clear cycle is neither stored nor counted.
- Reset (asynchronous, any time, including mid-burst): pointers, `level`, `ts`, `pend_lost` and `drop_cnt` go to 0. Storage contents are don't-care.

## Timing
- Reset values: out_valid 0, empty 1, full 0, level 0, drop_cnt 0, out_ts/out_tag/out_fmt/out_data/out_lost 0.
  - Head fields read from storage must be forced to 0 while empty.
- Capture-to-visible latency is 1 cycle: a push at edge N gives `out_valid=1` after edge N.
- `full`, `empty`, `level` and `drop_cnt` are registered and update on the edge that performs the push, pop, drop or clear.
- Head fields are stable while `out_valid && !out_ready`.
- No combinational path from `out_ready` to any output.
- Throughput: one push and one pop per cycle.

## Test plan
- Reset, then single event (tag 42, fmt DEC, data 7) at ts=5 -> next cycle out_valid=1, out_ts=5, out_tag=42, out_fmt=1, out_data=7, out_lost=0; pop -> empty=1.
- DEPTH=16, out_ready=0, 20 back-to-back events -> full=1 after 16, drop_cnt=4. Pop one, push one -> that entry has out_lost=4, and drop_cnt stays 4.
- Full FIFO with out_ready=1 and ev_valid=1 every cycle for 50 cycles -> level stays 16, drop_cnt stays 0, entries come out in order with consecutive timestamps.
- 300 drops with LOST_W=8 -> next stored entry out_lost=255 and drop_cnt=300. Then `clear` asserted together with ev_valid -> level=0, drop_cnt=0, event not stored.
- Let `ts` run to 2^TS_W-1 (force TS_W=8) and capture at ts=255 and at the next cycle -> out_ts 255 then 0.
- Assert rst_n low mid-burst with 5 entries queued -> outputs immediately take reset values. After release, the first new event reports out_lost=0.
